// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave over a BUFFER_SIZE-word register memory with independent read/write FSMs.
// Optional define AXI_LITE_SLAVE_ALIGN_CHECK_EN turns unaligned accesses into SLVERR.
module axi_lite_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int BUFFER_SIZE = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [1:0]            o_wr_state,
  output logic                  o_rd_state
);
  // Every channel uses the same rule: a beat transfers on the rising edge where valid && ready.

  localparam int OFF_BITS = $clog2(STRB_WIDTH);
  localparam int IDX_BITS = $clog2(BUFFER_SIZE);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(BUFFER_SIZE * STRB_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_LITE_SLAVE_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t              r_wstate;
  r_state_t              r_rstate;
  logic                  r_aw_got;
  logic                  r_w_got;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic [1:0]            r_bresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_mem [BUFFER_SIZE];

  logic                  w_aw_fire;
  logic                  w_w_fire;
  logic                  w_ar_fire;
  logic [ADDR_WIDTH-1:0] w_woff;
  logic [ADDR_WIDTH-1:0] w_roff;
  logic                  w_w_ok;
  logic                  w_r_ok;
  logic [IDX_BITS-1:0]   w_widx;
  logic [IDX_BITS-1:0]   w_ridx;

  // BASE_ADDR is span-aligned, so the low offset bits equal the low address bits.
  assign w_woff = r_awaddr - BASE_ADDR;
  assign w_roff = araddr - BASE_ADDR;
  assign w_w_ok = (w_woff < SPAN) && !(ALIGN_CHECK && (|w_woff[OFF_BITS-1:0]));
  assign w_r_ok = (w_roff < SPAN) && !(ALIGN_CHECK && (|w_roff[OFF_BITS-1:0]));
  assign w_widx = w_woff[OFF_BITS +: IDX_BITS];
  assign w_ridx = w_roff[OFF_BITS +: IDX_BITS];

  assign awready   = !rst && (r_wstate == W_IDLE) && !r_aw_got;
  assign wready    = !rst && (r_wstate == W_IDLE) && !r_w_got;
  assign bvalid    = (r_wstate == W_RESP);
  assign bresp     = r_bresp;
  assign arready   = !rst && (r_rstate == R_IDLE);
  assign rvalid    = (r_rstate == R_DATA);
  assign rdata     = r_rdata;
  assign rresp     = r_rresp;
  assign w_aw_fire = awvalid && awready;
  assign w_w_fire  = wvalid && wready;
  assign w_ar_fire = arvalid && arready;

  assign o_wr_state = r_wstate;
  assign o_rd_state = r_rstate;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
      for (int i = 0; i < BUFFER_SIZE; i++) r_mem[i] <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_fire) begin
            r_aw_got <= 1'b1;
            r_awaddr <= awaddr;
          end
          if (w_w_fire) begin
            r_w_got <= 1'b1;
            r_wdata <= wdata;
            r_wstrb <= wstrb;
          end
          if ((r_aw_got || w_aw_fire) && (r_w_got || w_w_fire)) r_wstate <= W_EXEC;
        end
        W_EXEC: begin
          if (w_w_ok) begin
            for (int b = 0; b < STRB_WIDTH; b++)
              if (r_wstrb[b]) r_mem[w_widx][8*b +: 8] <= r_wdata[8*b +: 8];
          end
          r_bresp  <= w_w_ok ? RESP_OKAY : RESP_SLVERR;
          r_aw_got <= 1'b0;
          r_w_got  <= 1'b0;
          r_wstate <= W_RESP;
        end
        W_RESP: if (bready) r_wstate <= W_IDLE;
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // A read sampled alongside W_EXEC sees the memory before that write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_fire) begin
            r_rdata  <= w_r_ok ? r_mem[w_ridx] : '0;
            r_rresp  <= w_r_ok ? RESP_OKAY : RESP_SLVERR;
            r_rstate <= R_DATA;
          end
        end
        R_DATA: if (rready) r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Self-checking bench for axi_lite_slave_mem (default parameters, 32-bit data, 32 words).
// Honours AXI_LITE_SLAVE_ALIGN_CHECK_EN in its reference model when the define is set.
module tb_axi_lite_slave_mem;
  localparam int BS = 32;
  localparam int SW = 4;
  localparam logic [31:0] BASE = 32'h0;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp, wr_state;
  logic rd_state;

  int total = 0;
  int bad = 0;
  logic [31:0] ref_mem [BS];
  logic [33:0] exp_q [$];

  always #5 clk = ~clk;

  axi_lite_slave_mem dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .o_wr_state(wr_state), .o_rd_state(rd_state)
  );

  // ---------------- reference model ----------------
  function automatic bit model_ok(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (off >= BS * SW) return 1'b0;
`ifdef AXI_LITE_SLAVE_ALIGN_CHECK_EN
    if (addr % SW != 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int idx;
    if (!model_ok(addr)) return 2'b10;
    idx = int'((addr - BASE) / SW);
    for (int b = 0; b < SW; b++)
      if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [31:0] addr);
    if (!model_ok(addr)) exp_q.push_back({2'b10, 32'h0});
    else exp_q.push_back({2'b00, ref_mem[int'((addr - BASE) / SW)]});
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < BS; i++) ref_mem[i] = 32'h0;
  endfunction

  // ---------------- driver tasks (entered just after a rising edge) ----------------
  task automatic send_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, output bit to);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int c = 0;
    to = 0;
    while (!(aw_done && w_done)) begin
      if (!aw_done && c >= aw_dly) begin awvalid = 1; awaddr = addr; end
      if (!w_done && c >= w_dly) begin wvalid = 1; wdata = data; wstrb = strb; end
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; awvalid = 0; end
      if (w_hs) begin w_done = 1; wvalid = 0; end
      c++;
      if (c > 200) begin to = 1; awvalid = 0; wvalid = 0; break; end
    end
  endtask

  task automatic wait_resp(output logic [1:0] resp, output int lat, output bit to);
    lat = 0; to = 0; resp = 2'bxx;
    bready = 0;
    do begin @(negedge clk); lat++; end while (!bvalid && lat < 200);
    if (!bvalid) begin to = 1; return; end
    resp = bresp;
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output int lat, output bit to);
    bit hs;
    int c = 0;
    to = 0; lat = 0; data = 'x; resp = 'x;
    arvalid = 1; araddr = addr;
    do begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1; c++;
    end while (!hs && c < 200);
    arvalid = 0;
    if (!hs) begin to = 1; return; end
    do begin @(negedge clk); lat++; end while (!rvalid && lat < 200);
    if (!rvalid) begin to = 1; return; end
    data = rdata; resp = rresp;
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int lat; bit to; logic [33:0] e;
    rst = 1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || {bresp, rresp} !== 4'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold: rdy/vld=%b resp=%b rdata=%h want 00000/0000/0",
               {awready, wready, arready, bvalid, rvalid}, {bresp, rresp}, rdata);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_reset();
    @(negedge clk);
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      bad++;
      $display("FAIL reset_release: rdy/vld=%b want 11100", {awready, wready, arready, bvalid, rvalid});
    end
    @(posedge clk); #1;
    model_read(32'h0);
    do_read(32'h0, d, r, lat, to);
    e = exp_q.pop_front();
    total++;
    if (to || {r, d} !== e || lat != 1) begin
      bad++;
      $display("FAIL reset_read0: got %h/%b lat=%0d to=%0d want %h/%b lat=1", d, r, lat, to, e[31:0], e[33:32]);
    end
  endtask

  task automatic test_full_write();
    logic [31:0] d; logic [1:0] r, er; int lat; bit to; logic [33:0] e;
    er = model_write(32'h10, 32'hDEADBEEF, 4'hF);
    send_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, to);
    wait_resp(r, lat, to);
    total++;
    if (to || r !== er || r !== 2'b00 || lat != 2) begin
      bad++;
      $display("FAIL full_wr_resp: bresp=%b lat=%0d to=%0d want 00 lat=2", r, lat, to);
    end
    model_read(32'h10);
    do_read(32'h10, d, r, lat, to);
    e = exp_q.pop_front();
    total++;
    if (to || d !== 32'hDEADBEEF || {r, d} !== e || lat != 1) begin
      bad++;
      $display("FAIL full_rd: got %h/%b lat=%0d want deadbeef/00 lat=1", d, r, lat);
    end
  endtask

  task automatic test_strobe_w_first();
    logic [31:0] d; logic [1:0] r, er; int lat; bit to; bit extra = 0;
    er = model_write(32'h10, 32'h11223344, 4'h5);
    send_write(32'h10, 32'h11223344, 4'h5, 3, 0, to);
    wait_resp(r, lat, to);
    total++;
    if (to || r !== er || lat != 2) begin
      bad++;
      $display("FAIL strb_resp: bresp=%b lat=%0d to=%0d want %b lat=2", r, lat, to, er);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bvalid) extra = 1;
    end
    @(posedge clk); #1;
    total++;
    if (extra) begin bad++; $display("FAIL strb_single: second bvalid seen, want none"); end
    do_read(32'h10, d, r, lat, to);
    total++;
    if (to || d !== 32'hDE22BE44 || r !== 2'b00) begin
      bad++;
      $display("FAIL strb_rd: got %h/%b want de22be44/00", d, r);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d, a; logic [1:0] r, er; int lat; bit to; logic [33:0] e;
    er = model_write(32'h80, 32'hCAFEF00D, 4'hF);
    send_write(32'h80, 32'hCAFEF00D, 4'hF, 0, 1, to);
    wait_resp(r, lat, to);
    total++;
    if (to || r !== 2'b10 || r !== er || lat != 2) begin
      bad++;
      $display("FAIL oor_wr: bresp=%b lat=%0d want 10 lat=2", r, lat);
    end
    er = model_write(32'h7C, 32'h0BADC0DE, 4'hF);
    send_write(32'h7C, 32'h0BADC0DE, 4'hF, 0, 0, to);
    wait_resp(r, lat, to);
    total++;
    if (to || r !== er) begin bad++; $display("FAIL last_word_wr: bresp=%b want %b", r, er); end
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: a = 32'h80;
        1: a = 32'hFFFFFFFC;
        2: a = 32'h7C;
        default: a = 32'h0;
      endcase
      model_read(a);
      do_read(a, d, r, lat, to);
      e = exp_q.pop_front();
      total++;
      if (to || {r, d} !== e) begin
        bad++;
        $display("FAIL oor_rd%0d: addr=%h got %h/%b want %h/%b", i, a, d, r, e[31:0], e[33:32]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d1, d2; logic [1:0] r, er1, er2; int lat; bit to;
    d1 = $urandom; d2 = $urandom;
    er1 = model_write(32'h04, d1, 4'hF);
    bready = 0;
    send_write(32'h04, d1, 4'hF, 0, 0, to);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bvalid && lat < 200);
    total++;
    if (!bvalid || lat != 2) begin bad++; $display("FAIL bp_first_b: bvalid=%b lat=%0d want 1 lat=2", bvalid, lat); end
    @(posedge clk); #1;
    fork
      begin : rd_branch
        logic [31:0] rd; logic [1:0] rr; int rl; bit rto; logic [33:0] e;
        model_read(32'h08);
        do_read(32'h08, rd, rr, rl, rto);
        e = exp_q.pop_front();
        total++;
        if (rto || {rr, rd} !== e || rl != 1) begin
          bad++;
          $display("FAIL bp_conc_rd: got %h/%b lat=%0d want %h/%b lat=1", rd, rr, rl, e[31:0], e[33:32]);
        end
      end
      begin : wr_branch
        awvalid = 1; awaddr = 32'h0C; wvalid = 1; wdata = d2; wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          total++;
          if (bvalid !== 1'b1 || bresp !== er1 || awready !== 1'b0 || wready !== 1'b0) begin
            bad++;
            $display("FAIL bp_stall%0d: bvalid=%b bresp=%b awready=%b wready=%b want 1/%b/0/0",
                     i, bvalid, bresp, awready, wready, er1);
          end
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        @(negedge clk);
        total++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
          bad++;
          $display("FAIL bp_release: awready=%b bvalid=%b want 1/0", awready, bvalid);
        end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        er2 = model_write(32'h0C, d2, 4'hF);
        wait_resp(r, lat, to);
        total++;
        if (to || r !== er2 || lat != 2) begin
          bad++;
          $display("FAIL bp_second_wr: bresp=%b lat=%0d want %b lat=2", r, lat, er2);
        end
      end
    join
    do_read(32'h04, d2, r, lat, to);
    total++;
    if (to || d2 !== d1 || r !== 2'b00) begin bad++; $display("FAIL bp_rd04: got %h/%b want %h/00", d2, r, d1); end
  endtask

  task automatic test_align();
    logic [31:0] d; logic [1:0] r, er; int lat; bit to; logic [33:0] e;
    er = model_write(32'h02, 32'hA5A5A5A5, 4'hF);
    send_write(32'h02, 32'hA5A5A5A5, 4'hF, 0, 0, to);
    wait_resp(r, lat, to);
    total++;
    if (to || r !== er) begin bad++; $display("FAIL align_wr: bresp=%b want %b", r, er); end
    for (int i = 0; i < 2; i++) begin
      model_read(i == 0 ? 32'h0 : 32'h3);
      do_read(i == 0 ? 32'h0 : 32'h3, d, r, lat, to);
      e = exp_q.pop_front();
      total++;
      if (to || {r, d} !== e) begin
        bad++;
        $display("FAIL align_rd%0d: got %h/%b want %h/%b", i, d, r, e[31:0], e[33:32]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int lat; bit to; bit seen = 0;
    send_write(32'h20, 32'h12345678, 4'hF, 0, 0, to);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    bready = 1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (bvalid) seen = 1; end
    @(posedge clk); #1;
    bready = 0;
    total++;
    if (seen || awready !== 1'b1) begin bad++; $display("FAIL mid_reset_drop: bvalid_seen=%0d awready=%b want 0/1", seen, awready); end
    do_read(32'h20, d, r, lat, to);
    total++;
    if (to || d !== 32'h0 || r !== 2'b00) begin bad++; $display("FAIL mid_reset_rd: got %h/%b want 0/00", d, r); end
  endtask

  task automatic test_random();
    logic [31:0] a, d; logic [3:0] s; logic [1:0] r, er; int lat; bit to; logic [33:0] e;
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 39) * 4) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        er = model_write(a, d, s);
        send_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), to);
        wait_resp(r, lat, to);
        total++;
        if (to || r !== er || lat != 2) begin
          bad++;
          $display("FAIL rnd_wr%0d: addr=%h bresp=%b lat=%0d want %b lat=2", n, a, r, lat, er);
        end
      end else begin
        model_read(a);
        do_read(a, d, r, lat, to);
        e = exp_q.pop_front();
        total++;
        if (to || {r, d} !== e || lat != 1) begin
          bad++;
          $display("FAIL rnd_rd%0d: addr=%h got %h/%b want %h/%b", n, a, d, r, e[31:0], e[33:32]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_strobe_w_first();
    test_out_of_range();
    test_backpressure();
    test_align();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_slave_mem.md
Name: axi_lite_slave_mem

Overview:
- Parametrised AXI4-Lite slave backed by a word-addressed register memory of BUFFER_SIZE words.
- Independent read and write channel FSMs, byte-strobe writes, and out-of-range decode to SLVERR.
- Serves as the DUT-side slave in the verification environment and as the reference memory model the scoreboard mirrors.

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- DATA_WIDTH, 32, data width in bits; legal values 32 or 64.
- STRB_WIDTH, DATA_WIDTH/8, strobe width; derived, not overridden.
- BUFFER_SIZE, 32, number of memory words; power of two, at least 2.
- BASE_ADDR, 0, byte address of word 0; aligned to BUFFER_SIZE*STRB_WIDTH.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- awaddr  in  ADDR_WIDTH  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  STRB_WIDTH  byte strobes; bit i enables byte i.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_WIDTH  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset is sampled on the rising edge of clk and overrides all other activity.
- Values while reset is asserted:
  - awready, wready, arready, bvalid and rvalid are 0.
  - bresp, rresp and rdata are 0.
  - All memory words are 0.
  - Both FSMs return to IDLE.
- Reset mid-transaction: any in-flight transaction is dropped, with no memory update and no response.
- Address decode:
  - off = addr - BASE_ADDR, computed modulo 2^ADDR_WIDTH.
  - in range when off < BUFFER_SIZE*STRB_WIDTH.
  - word index = off >> log2(STRB_WIDTH); the low log2(STRB_WIDTH) bits are ignored.
- Write FSM states: W_IDLE, W_EXEC, W_RESP.
  - W_IDLE: awready is 1 until AW is captured, then 0. wready is 1 until W is captured, then 0.
  - AW and W may be captured in either order or in the same cycle. A captured beat is held in registers.
  - Both captured: go to W_EXEC on the next edge.
  - W_EXEC lasts 1 cycle. For an in-range address, each byte whose wstrb bit is set is written at the end of the cycle. bresp = OKAY if in range, else SLVERR, and the memory is untouched. Then go to W_RESP.
  - W_RESP: bvalid is 1 and bresp is stable until bready. On the bvalid&&bready edge go to W_IDLE; awready and wready return to 1 on the next cycle.
  - awready and wready are 0 in W_EXEC and W_RESP.
  - Minimum write latency: bvalid rises 2 cycles after the later of the AW/W handshakes.
  - wstrb = 0 on an in-range address: OKAY response, memory unchanged.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready is 1. On arvalid&&arready, rdata is registered and the FSM goes to R_DATA.
  - rdata is mem[index] if in range; otherwise rdata = 0 and rresp = SLVERR.
  - R_DATA: rvalid is 1; rdata and rresp are stable until rready. On handshake go to R_IDLE; arready is 1 on the next cycle.
  - Read latency: rvalid is 1 in the cycle immediately after the AR handshake.
  - Throughput: one read every 2 cycles when rready is held at 1.
- Simultaneous read and write:
  - The two channels are fully independent.
  - If the AR handshake coincides with W_EXEC to the same word, the read returns the pre-write data.
  - A read whose AR handshake is in any later cycle returns the new data.
- Backpressure: holding bready or rready low stalls only that channel. The other channel continues normally.

Optional Feature:
- Macro: AXI_LITE_SLAVE_ALIGN_CHECK_EN.
- When defined:
  - A write with non-zero low log2(STRB_WIDTH) address bits gets SLVERR and no memory update.
  - An unaligned read returns rdata = 0 and rresp = SLVERR.
- When not defined: the low address bits are ignored, and unaligned accesses behave as the aligned word access with OKAY.

Test Plan:
- Reset then idle: assert rst for 3 cycles, release. Required: awready, wready and arready are 1 on the first cycle after release; bvalid and rvalid are 0; a read of 0x0 returns 0x00000000 with OKAY.
- Full write and read-back: AW 0x10 and W 0xDEADBEEF with wstrb 0xF in the same cycle, then read 0x10. Required: bvalid 2 cycles after the handshake with bresp 00; rdata 0xDEADBEEF; rresp 00.
- Strobes and W before AW: W 0x11223344 with wstrb 0x5, sent 3 cycles before AW 0x10, onto 0xDEADBEEF. Required: a single write occurs; read-back 0xDE22BE44.
- Out of range, BUFFER_SIZE = 32: write to 0x80, then read 0x80. Required: bresp 10 and memory unchanged; rdata 0 and rresp 10.
- Backpressure and concurrency: hold bready = 0 for 5 cycles after a write to 0x04. Required: bvalid and bresp stay stable; a concurrent read of 0x08 completes unaffected; the next AW is not accepted until the B handshake.
- Align check (macro defined): write to 0x02. Required: SLVERR; word 0 unchanged. Macro undefined: OKAY, and word 0 is written.
